// File: rtl/vending_machine.sv
// Vending machine: keypad scanner, key-event filter, seven-state sale FSM, three seven-segment digits.
// Latency: key seen at a scan edge -> FSM acts one clock later -> digits update one clock after that.
// Backpressure: none; the keypad is free-running, and keys the current state does not accept are dropped.
// Ports: clk, reset (async, active-high) | row[3:0] keypad rows, active-low |
//        shift_col[3:0] one-cold column scan | D0 units, D1 tens, D2 state number, segments {g,f,e,d,c,b,a}, active-low.
module vending_machine (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] shift_col,
    output logic [6:0] D0,
    output logic [6:0] D1,
    output logic [6:0] D2
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SELECT   = 3'd1,
        S_CHOSEN   = 3'd2,
        S_PAY      = 3'd3,
        S_PARTIAL  = 3'd4,
        S_REFUND   = 3'd5,
        S_DISPENSE = 3'd6
    } state_t;

    localparam logic [3:0] KEY_CANCEL  = 4'hE;
    localparam logic [3:0] KEY_CONFIRM = 4'hF;
    localparam logic [6:0] SEG_ZERO    = 7'b1000000;

    // ---------------- keypad scan and decode ----------------
    logic [3:0] col_q;
    logic [1:0] col_idx;
    logic [1:0] row_idx;
    logic       row_hit;
    logic [3:0] key_code;
    logic       key_fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) col_q <= 4'b1110;
        else       col_q <= {col_q[2:0], col_q[3]};
    end

    assign shift_col = col_q;

    // Row lines are read against the column driven during the same cycle.
    always_comb begin
        col_idx = 2'd0;
        case (col_q)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
        row_idx = 2'd0;
        row_hit = 1'b0;
        case (row)
            4'b1110: begin row_idx = 2'd0; row_hit = 1'b1; end
            4'b1101: begin row_idx = 2'd1; row_hit = 1'b1; end
            4'b1011: begin row_idx = 2'd2; row_hit = 1'b1; end
            4'b0111: begin row_idx = 2'd3; row_hit = 1'b1; end
            default: begin row_idx = 2'd0; row_hit = 1'b0; end  // none or several rows low
        endcase
        key_code = {col_idx, row_idx};
    end

    // ---------------- key event filter ----------------
    // A held key only pulls its row low once per scan pass, so it never produces
    // four idle reads in a row; four idle reads therefore mean a real release.
    logic       ev_q;
    logic [3:0] ev_key_q;
    logic       last_vld_q;
    logic [3:0] last_key_q;
    logic [2:0] idle_cnt_q;
    logic       released_q;

    assign key_fire = row_hit && (!last_vld_q || (key_code != last_key_q) || released_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ev_q       <= 1'b0;
            ev_key_q   <= 4'd0;
            last_vld_q <= 1'b0;
            last_key_q <= 4'd0;
            idle_cnt_q <= 3'd0;
            released_q <= 1'b0;
        end else begin
            ev_q <= key_fire;
            if (key_fire) begin
                ev_key_q   <= key_code;
                last_key_q <= key_code;
                last_vld_q <= 1'b1;
            end
            if (row == 4'b1111) begin
                if (idle_cnt_q != 3'd4) idle_cnt_q <= idle_cnt_q + 3'd1;
            end else begin
                idle_cnt_q <= 3'd0;
            end
            if (key_fire)
                released_q <= 1'b0;
            else if ((row == 4'b1111) && (idle_cnt_q == 3'd3))
                released_q <= 1'b1;
        end
    end

    // ---------------- sale FSM ----------------
    state_t     state_q, state_d;
    logic [3:0] p_q, p_d;
    logic [7:0] credit_q, credit_d;
    logic [3:0] timer_q, timer_d;
    logic [7:0] price;
    logic [2:0] coin_val;
    logic       is_coin;
    logic       is_digit;
    logic [7:0] credit_sum;

    assign price = {2'b00, p_q, 2'b00} + {4'b0000, p_q};  // 5 * p

    always_comb begin
        coin_val = 3'd0;
        case (ev_key_q)
            4'h1:    coin_val = 3'd1;
            4'h2:    coin_val = 3'd2;
            4'h5:    coin_val = 3'd5;
            default: coin_val = 3'd0;
        endcase
        is_coin    = (coin_val != 3'd0);
        is_digit   = (ev_key_q >= 4'h1) && (ev_key_q <= 4'h9);
        credit_sum = credit_q + {5'b00000, coin_val};
    end

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        credit_d = credit_q;
        timer_d  = timer_q;
        case (state_q)
            S_IDLE: begin
                if (ev_q && ev_key_q == KEY_CONFIRM) state_d = S_SELECT;
            end
            S_SELECT, S_CHOSEN: begin
                if (ev_q) begin
                    if (is_digit) begin
                        p_d     = ev_key_q;
                        state_d = S_CHOSEN;
                    end else if (ev_key_q == KEY_CANCEL) begin
                        p_d     = 4'd0;
                        state_d = S_IDLE;
                    end else if (ev_key_q == KEY_CONFIRM && state_q == S_CHOSEN) begin
                        state_d = S_PAY;
                    end
                end
            end
            S_PAY, S_PARTIAL: begin
                if (ev_q) begin
                    if (is_coin) begin
                        credit_d = credit_sum;
                        timer_d  = 4'd0;
                        state_d  = (credit_sum >= price) ? S_DISPENSE : S_PARTIAL;
                    end else if (ev_key_q == KEY_CANCEL) begin
                        timer_d = 4'd0;
                        state_d = S_REFUND;
                    end
                end
            end
            S_REFUND, S_DISPENSE: begin
                // Timer runs 0..15 while in the state, giving exactly 16 clocks.
                if (timer_q == 4'd15) begin
                    state_d  = S_IDLE;
                    credit_d = 8'd0;
                    p_d      = 4'd0;
                    timer_d  = 4'd0;
                end else begin
                    timer_d = timer_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            p_q      <= 4'd0;
            credit_q <= 8'd0;
            timer_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            credit_q <= credit_d;
            timer_q  <= timer_d;
        end
    end

    // ---------------- display ----------------
    function automatic logic [6:0] seg7(input logic [7:0] d);
        case (d)
            8'd0:    return 7'b1000000;
            8'd1:    return 7'b1111001;
            8'd2:    return 7'b0100100;
            8'd3:    return 7'b0110000;
            8'd4:    return 7'b0011001;
            8'd5:    return 7'b0010010;
            8'd6:    return 7'b0000010;
            8'd7:    return 7'b1111000;
            8'd8:    return 7'b0000000;
            8'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Values never exceed 49, so nine conditional subtractions cover every tens digit.
    function automatic logic [7:0] to_bcd(input logic [7:0] v);
        logic [7:0] rem;
        logic [3:0] tens;
        rem  = v;
        tens = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 8'd10) begin
                rem  = rem - 8'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    logic [7:0] disp_val;
    logic [7:0] disp_bcd;
    logic [6:0] d0_q, d1_q, d2_q;

    always_comb begin
        disp_val = 8'd0;
        case (state_q)
            S_CHOSEN, S_PAY:     disp_val = price;
            S_PARTIAL, S_REFUND: disp_val = credit_q;
            S_DISPENSE:          disp_val = credit_q - price;
            default:             disp_val = 8'd0;
        endcase
        disp_bcd = to_bcd(disp_val);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d0_q <= SEG_ZERO;
            d1_q <= SEG_ZERO;
            d2_q <= SEG_ZERO;
        end else begin
            d0_q <= seg7({4'b0000, disp_bcd[3:0]});
            d1_q <= seg7({4'b0000, disp_bcd[7:4]});
            d2_q <= seg7({5'b00000, state_q});
        end
    end

    assign D0 = d0_q;
    assign D1 = d1_q;
    assign D2 = d2_q;

endmodule

// File: tb/tb_vending_machine.sv
// Bench for vending_machine: keypad model driving row from shift_col, transaction-level reference model.
module tb_vending_machine;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row;
    logic [3:0] shift_col;
    logic [6:0] D0, D1, D2;

    logic       key_down;
    logic [3:0] key_code;
    logic       force_en;
    logic [3:0] force_val;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: state number, product, credit
    int m_state, m_p, m_credit;

    logic [3:0] scan_exp [3] = '{4'b1101, 4'b1011, 4'b0111};

    vending_machine dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .shift_col (shift_col),
        .D0        (D0),
        .D1        (D1),
        .D2        (D2)
    );

    always #5 clk = ~clk;

    function automatic int col_of(input logic [3:0] sc);
        case (sc)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // Physical keypad: a pressed key pulls its row low only while its column is driven.
    assign row = force_en ? force_val :
                 (key_down && col_of(shift_col) == int'(key_code[3:2])) ? ~(4'b0001 << key_code[1:0]) :
                 4'b1111;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_state = 0; m_p = 0; m_credit = 0;
    endfunction

    function automatic void m_apply(input int k);
        case (m_state)
            0: if (k == 15) m_state = 1;
            1, 2: begin
                if (k >= 1 && k <= 9) begin m_p = k; m_state = 2; end
                else if (k == 14) begin m_p = 0; m_state = 0; end
                else if (k == 15 && m_state == 2) m_state = 3;
            end
            3, 4: begin
                if (k == 1 || k == 2 || k == 5) begin
                    m_credit += k;
                    m_state = (m_credit >= 5 * m_p) ? 6 : 4;
                end else if (k == 14) m_state = 5;
            end
            default: ;
        endcase
    endfunction

    function automatic int m_value();
        case (m_state)
            2, 3:    return 5 * m_p;
            4, 5:    return m_credit;
            6:       return m_credit - 5 * m_p;
            default: return 0;
        endcase
    endfunction

    task automatic check_disp(input string tag);
        int v;
        v = m_value();
        check({tag, "_D2"}, {1'b0, D2}, {1'b0, seg(m_state)});
        check({tag, "_D1"}, {1'b0, D1}, {1'b0, seg(v / 10)});
        check({tag, "_D0"}, {1'b0, D0}, {1'b0, seg(v % 10)});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold >= 4 clocks covers one full scan pass; 6 idle clocks let the action reach the digits.
    task automatic press(input logic [3:0] k, input int hold);
        key_code = k;
        key_down = 1'b1;
        tick(hold);
        key_down = 1'b0;
        tick(6);
    endtask

    // Press a key expected to enter a timed state, count clocks D2 shows it, capture the value shown.
    task automatic press_timed(input logic [3:0] k, input int st, output int cnt,
                               output logic [6:0] d1s, output logic [6:0] d0s);
        cnt = 0; d1s = 7'h7f; d0s = 7'h7f;
        key_code = k;
        key_down = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i == 3) key_down = 1'b0;
            if (D2 == seg(st)) begin
                if (cnt == 0) begin d1s = D1; d0s = D0; end
                cnt++;
            end else if (cnt > 0) begin
                break;
            end
        end
        key_down = 1'b0;
    endtask

    task automatic timed_step(input string tag, input logic [3:0] k);
        int cnt, v, st;
        logic [6:0] d1s, d0s;
        m_apply(int'(k));
        st = m_state;
        v  = m_value();
        press_timed(k, st, cnt, d1s, d0s);
        check({tag, "_len"}, cnt[7:0], 8'd16);
        check({tag, "_D1"}, {1'b0, d1s}, {1'b0, seg(v / 10)});
        check({tag, "_D0"}, {1'b0, d0s}, {1'b0, seg(v % 10)});
        m_reset();
        tick(2);
        check_disp({tag, "_exit"});
    endtask

    task automatic step(input string tag, input logic [3:0] k);
        m_apply(int'(k));
        press(k, 4);
        check_disp(tag);
    endtask

    initial begin
        int r, k;
        reset = 1'b1; key_down = 1'b0; key_code = 4'h0; force_en = 1'b0; force_val = 4'b1111;
        m_reset();

        // reset then idle scan
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_D0", {1'b0, D0}, 8'h40);
        check("rst_D1", {1'b0, D1}, 8'h40);
        check("rst_D2", {1'b0, D2}, 8'h40);
        check("rst_col", {4'h0, shift_col}, 8'h0e);
        reset = 1'b0;
        #1 check("rel_col", {4'h0, shift_col}, 8'h0e);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("scan_col", {4'h0, shift_col}, {4'h0, scan_exp[i]});
        end
        tick(2);

        // several rows low at once is not a key
        force_en = 1'b1; force_val = 4'b0110;
        tick(8);
        force_en = 1'b0;
        tick(6);
        check_disp("multi_row");

        // selection F,1,F
        step("sel_F", 4'hF);
        step("sel_1", 4'h1);
        check("sel_1_D0", {1'b0, D0}, {1'b0, 7'b0010010});
        step("sel_F2", 4'hF);
        // cancel from S3 -> refund showing 00 for 16 clocks
        timed_step("cancel", 4'hE);

        // payment F,3,F then coins 5,2,5,5
        step("pay_F", 4'hF);
        step("pay_3", 4'h3);
        step("pay_F2", 4'hF);
        step("coin5", 4'h5);
        step("coin2", 4'h2);
        step("coin5b", 4'h5);
        check("coin5b_D1", {1'b0, D1}, {1'b0, 7'b1111001});
        timed_step("dispense", 4'h5);

        // held F gives one event; a repeat press of F in S1 is ignored
        m_apply(15);
        press(4'hF, 20);
        check_disp("hold_F");
        step("again_F", 4'hF);
        step("sel_E", 4'hE);

        // held coin counts once; then reset in S4 with credit 7
        step("h_F", 4'hF);
        step("h_2", 4'h2);
        step("h_F2", 4'hF);
        m_apply(2);
        press(4'h2, 20);
        check_disp("hold_coin");
        step("h_coin5", 4'h5);
        check("h_coin5_D0", {1'b0, D0}, {1'b0, 7'b1111000});
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_D0", {1'b0, D0}, 8'h40);
        check("mid_rst_D1", {1'b0, D1}, 8'h40);
        check("mid_rst_D2", {1'b0, D2}, 8'h40);
        check("mid_rst_col", {4'h0, shift_col}, 8'h0e);
        m_reset();
        tick(2);
        reset = 1'b0;
        tick(6);
        check_disp("after_rst");
        step("ar_F", 4'hF);
        step("ar_1", 4'h1);
        step("ar_F2", 4'hF);
        step("ar_coin2", 4'h2);   // credit must restart from zero: 5 -> S6 change 0 would differ
        timed_step("ar_coin5", 4'h5);

        // randomized key sequence against the model
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7) begin
                case ($urandom_range(0, 6))
                    0:       k = 15;
                    1:       k = 14;
                    2:       k = 1;
                    3:       k = 2;
                    4:       k = 5;
                    5:       k = 15;
                    default: k = int'($urandom_range(1, 9));
                endcase
            end else begin
                k = int'($urandom_range(0, 15));
            end
            begin
                int probe_state, probe_p, probe_credit;
                probe_state = m_state; probe_p = m_p; probe_credit = m_credit;
                m_apply(k);
                if (m_state == 5 || m_state == 6) begin
                    m_state = probe_state; m_p = probe_p; m_credit = probe_credit;
                    timed_step("rnd_t", k[3:0]);
                end else begin
                    press(k[3:0], 4);
                    check_disp("rnd");
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
